// File: rtl/msg_pkg.sv
// rtl/msg_pkg.sv - shared constants, FSM encoding and bit-reverse helper for msg_word_assembler
package msg_pkg;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_ONE  = 8'h31;
  localparam int         REV_MAX   = 64;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // Reverses the low 'width' bits of din; bits at and above 'width' come back as zero.
  function automatic logic [REV_MAX-1:0] bit_reverse(input logic [REV_MAX-1:0] din,
                                                     input int width);
    logic [REV_MAX-1:0] full_rev;
    full_rev = {<<{din}};
    return full_rev >> (REV_MAX - width);
  endfunction

endpackage

// File: rtl/msg_fifo.sv
// rtl/msg_fifo.sv - synchronous first-word-fall-through FIFO with exact level count
module msg_fifo
  import msg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int LW    = $clog2(DEPTH + 1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_pop;
  logic             w_do_push;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign empty = (r_level == '0);
  assign full  = (r_level == LW'(DEPTH));
  assign level = r_level;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/msg_word_assembler.sv
// rtl/msg_word_assembler.sv - packs ASCII '0'/'1' characters into WIDTH-bit words behind a FIFO
module msg_word_assembler
  import msg_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CW    = $clog2(WIDTH + 1),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_char,
  output logic             in_ready,
  input  logic             flush,
  input  logic             rev_en,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [LW-1:0]    level,
  output logic [CW-1:0]    bit_cnt,
  output logic             bad_char
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_word;
  logic [WIDTH-1:0] r_hold;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_bad;

  logic             w_accept;
  logic             w_is_zero;
  logic             w_is_one;
  logic [WIDTH-1:0] w_word_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_commit;
  logic             w_space;
  logic             w_push;
  logic             w_hold_load;
  logic [WIDTH-1:0] w_fifo_din;
  logic [WIDTH-1:0] w_head;
  logic             w_empty;
  logic             w_full;

  assign in_ready  = (r_state == ST_FILL);
  assign w_accept  = in_valid && in_ready;
  assign w_is_zero = (in_char == CHAR_ZERO);
  assign w_is_one  = (in_char == CHAR_ONE);

  // Bits above bit_cnt are always zero, so OR-ing in the new bit is enough and
  // a flushed partial word comes out zero-padded for free.
  always_comb begin
    w_word_nxt = r_word;
    w_cnt_nxt  = r_bit_cnt;
    if (w_accept && (w_is_zero || w_is_one)) begin
      w_word_nxt = r_word | ({{(WIDTH-1){1'b0}}, w_is_one} << r_bit_cnt);
      w_cnt_nxt  = r_bit_cnt + 1'b1;
    end
  end

  assign w_commit = (r_state == ST_FILL) &&
                    ((w_cnt_nxt == CW'(WIDTH)) || (flush && (w_cnt_nxt != '0)));
  assign w_space  = !w_full || (out_ready && !w_empty);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_hold_load = 1'b0;
    w_fifo_din  = w_word_nxt;
    case (r_state)
      ST_FILL: begin
        if (w_commit) begin
          if (w_space) begin
            w_push = 1'b1;
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = ST_STALL;
          end
        end
      end
      ST_STALL: begin
        w_fifo_din = r_hold;
        if (w_space) begin
          w_push      = 1'b1;
          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= ST_FILL;
      r_word    <= '0;
      r_hold    <= '0;
      r_bit_cnt <= '0;
      r_bad     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept && !w_is_zero && !w_is_one) r_bad <= 1'b1;
      if (w_commit) begin
        r_word    <= '0;
        r_bit_cnt <= '0;
      end else begin
        r_word    <= w_word_nxt;
        r_bit_cnt <= w_cnt_nxt;
      end
      if (w_hold_load) r_hold <= w_word_nxt;
    end
  end

  msg_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (out_ready),
    .din   (w_fifo_din),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full),
    .level (level)
  );

  assign out_valid = !w_empty;
  assign out_data  = rev_en ? WIDTH'(bit_reverse(REV_MAX'(w_head), WIDTH)) : w_head;
  assign bit_cnt   = r_bit_cnt;
  assign bad_char  = r_bad;

endmodule

// File: tb/tb_msg_word_assembler.sv
// tb/tb_msg_word_assembler.sv - directed self-checking bench for msg_word_assembler
module tb_msg_word_assembler;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       flush;
  logic       rev_en;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [2:0] level;
  logic [3:0] bit_cnt;
  logic       bad_char;

  int n_vec = 0;
  int n_err = 0;

  msg_word_assembler #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .flush     (flush),
    .rev_en    (rev_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .bit_cnt   (bit_cnt),
    .bad_char  (bad_char)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL rst_level: got %0d want 0", level); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_out_data: got %h want 00", out_data); end
    n_vec++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL rst_bit_cnt: got %0d want 0", bit_cnt); end
    n_vec++; if (bad_char !== 1'b0) begin n_err++; $display("FAIL rst_bad_char: got %b want 0", bad_char); end
  endtask

  task automatic test_basic_word();
    send_str("1011000");
    n_vec++; if (bit_cnt !== 4'd7) begin n_err++; $display("FAIL basic_cnt7: got %0d want 7", bit_cnt); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    send("0");
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL basic_level: got %0d want 1", level); end
    n_vec++; if (out_data !== 8'h0D) begin n_err++; $display("FAIL basic_data: got %h want 0d", out_data); end
    n_vec++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL basic_cnt0: got %0d want 0", bit_cnt); end
    rev_en = 1'b1;
    #1;
    n_vec++; if (out_data !== 8'hB0) begin n_err++; $display("FAIL basic_rev: got %h want b0", out_data); end
    rev_en = 1'b0;
    #1;
    n_vec++; if (out_data !== 8'h0D) begin n_err++; $display("FAIL basic_unrev: got %h want 0d", out_data); end
    pop_one();
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL basic_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_flush();
    send_str("11");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL flush_level: got %0d want 1", level); end
    n_vec++; if (out_data !== 8'h03) begin n_err++; $display("FAIL flush_data: got %h want 03", out_data); end
    n_vec++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL flush_cnt: got %0d want 0", bit_cnt); end
    pop_one();
    in_valid = 1'b1;
    in_char  = "1";
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    n_vec++; if (out_data !== 8'h01) begin n_err++; $display("FAIL flush_same_cycle: got %h want 01", out_data); end
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL flush_same_level: got %0d want 1", level); end
    pop_one();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL flush_empty_word: got %0d want 0", level); end
  endtask

  task automatic test_bad_char();
    send_str("1x000000");
    n_vec++; if (bit_cnt !== 4'd7) begin n_err++; $display("FAIL bad_cnt: got %0d want 7", bit_cnt); end
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL bad_level0: got %0d want 0", level); end
    n_vec++; if (bad_char !== 1'b1) begin n_err++; $display("FAIL bad_flag: got %b want 1", bad_char); end
    send("0");
    n_vec++; if (out_data !== 8'h01) begin n_err++; $display("FAIL bad_data: got %h want 01", out_data); end
    n_vec++; if (level !== 3'd1) begin n_err++; $display("FAIL bad_level1: got %0d want 1", level); end
    pop_one();
    n_vec++; if (bad_char !== 1'b1) begin n_err++; $display("FAIL bad_sticky: got %b want 1", bad_char); end
  endtask

  task automatic test_stall();
    for (int w = 0; w < 4; w++) send_str("11111111");
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL stall_full_level: got %0d want 4", level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_pre_ready: got %b want 1", in_ready); end
    send_str("01010101");
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready: got %b want 0", in_ready); end
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL stall_level: got %0d want 4", level); end
    in_valid = 1'b1;
    in_char  = "1";
    flush    = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    n_vec++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL stall_no_accept: got %0d want 0", bit_cnt); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_hold: got %b want 0", in_ready); end
    pop_one();
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL stall_release_level: got %0d want 4", level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_q [4];
    exp_q = '{8'hFF, 8'hFF, 8'hAA, 8'h33};
    send_str("1100110");
    out_ready = 1'b1;
    send("0");
    out_ready = 1'b0;
    n_vec++; if (level !== 3'd4) begin n_err++; $display("FAIL full_pp_level: got %0d want 4", level); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_pp_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (out_data !== exp_q[i]) begin n_err++; $display("FAIL order_%0d: got %h want %h", i, out_data, exp_q[i]); end
      pop_one();
    end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 8'h00) begin n_err++; $display("FAIL drain_data: got %h want 00", out_data); end
    pop_one();
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL empty_pop_level: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid();
    send_str("100000001000000010000000");
    send_str("1x1010");
    n_vec++; if (level !== 3'd3) begin n_err++; $display("FAIL mid_pre_level: got %0d want 3", level); end
    n_vec++; if (bit_cnt !== 4'd5) begin n_err++; $display("FAIL mid_pre_cnt: got %0d want 5", bit_cnt); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    n_vec++; if (level !== 3'd0) begin n_err++; $display("FAIL mid_level: got %0d want 0", level); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    n_vec++; if (bit_cnt !== 4'd0) begin n_err++; $display("FAIL mid_cnt: got %0d want 0", bit_cnt); end
    n_vec++; if (bad_char !== 1'b0) begin n_err++; $display("FAIL mid_bad: got %b want 0", bad_char); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    flush     = 1'b0;
    rev_en    = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic_word();
    test_flush();
    test_bad_char();
    test_stall();
    test_full_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
